// File: rtl/nibble_bus_pkg.sv
// Shared types and defaults for the nibble bus reader slice.
package nibble_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        SAMPLE  = 3'd2,
        RELEASE = 3'd3,
        HOLD    = 3'd4
    } rd_state_e;

    localparam int NIB_W_DEF    = 4;
    localparam int NUM_NIB_DEF  = 4;
    localparam int TURN_CYC_DEF = 1;

    // Both counters only ever need to reach 15 (NUM_NIB and TURN_CYC are capped at 16).
    localparam int CNT_W = 4;

endpackage

// File: rtl/nibble_bus_reader_if.sv
// Control, tristate-bus and valid/ready signals of one nibble bus reader.
interface nibble_bus_reader_if import nibble_bus_pkg::*; #(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF
) ();

    logic                     start;
    logic                     busy;
    logic                     bus_en;
    logic [NIB_W-1:0]         bus_y;
    logic [NIB_W*NUM_NIB-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_ready;

    modport master (
        input  start, bus_y, rd_ready,
        output busy, bus_en, rd_data, rd_valid
    );

    modport slave (
        output start, bus_y, rd_ready,
        input  busy, bus_en, rd_data, rd_valid
    );

endinterface

// File: rtl/nibble_shift_capture.sv
// Shadow word of NUM_NIB nibble slots; one slot written per enabled cycle at idx.
module nibble_shift_capture import nibble_bus_pkg::*; #(
    parameter int NIB_W   = NIB_W_DEF,
    parameter int NUM_NIB = NUM_NIB_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic [CNT_W-1:0]         idx,
    input  logic [NIB_W-1:0]         din,
    output logic [NIB_W*NUM_NIB-1:0] word
);

    for (genvar k = 0; k < NUM_NIB; k++) begin : g_slot
        logic [NIB_W-1:0] q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (clr)
                q <= '0;
            else if (we && idx == CNT_W'(k))
                q <= din;
        end

        assign word[k*NIB_W +: NIB_W] = q;
    end

endmodule

// File: rtl/nibble_bus_reader.sv
// Receiving end of the shared tristate nibble bus: enable driver, wait turnaround,
// sample NUM_NIB nibbles LSB first, release the bus, then offer the word on valid/ready.
module nibble_bus_reader import nibble_bus_pkg::*; #(
    parameter int NIB_W    = NIB_W_DEF,
    parameter int NUM_NIB  = NUM_NIB_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_bus_reader_if.master  bus
);

    localparam int WORD_W = NIB_W * NUM_NIB;
    // TURN_LAST is meaningless when TURN_CYC=0; TURN is never entered then.
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [CNT_W-1:0] NIB_LAST  = CNT_W'(NUM_NIB - 1);

    rd_state_e         state, state_nxt;
    logic [CNT_W-1:0]  turn_cnt, nib_cnt;
    logic [WORD_W-1:0] shadow, rd_data_q;
    logic              cap_clr, cap_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = (TURN_CYC == 0) ? SAMPLE : TURN;
            TURN:    if (turn_cnt == TURN_LAST) state_nxt = SAMPLE;
            SAMPLE:  if (nib_cnt == NIB_LAST) state_nxt = RELEASE;
            RELEASE: state_nxt = HOLD;
            HOLD:    if (bus.rd_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Everything visible is a decode of the state register, so reset kills bus_en at once.
    always_comb begin
        bus.busy     = (state != IDLE);
        bus.bus_en   = (state == TURN) || (state == SAMPLE);
        bus.rd_valid = (state == HOLD);
        cap_clr      = (state == IDLE) && bus.start;
        cap_we       = (state == SAMPLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_cnt <= '0;
            nib_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    turn_cnt <= '0;
                    nib_cnt  <= '0;
                end
                TURN:    turn_cnt <= turn_cnt + 1'b1;
                SAMPLE:  nib_cnt  <= nib_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    nibble_shift_capture #(
        .NIB_W   (NIB_W),
        .NUM_NIB (NUM_NIB)
    ) u_cap (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cap_clr),
        .we    (cap_we),
        .idx   (nib_cnt),
        .din   (bus.bus_y),
        .word  (shadow)
    );

    // Separate output register so rd_data holds the last word while the next one fills the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_data_q <= '0;
        else if (state == RELEASE)
            rd_data_q <= shadow;
    end

    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_nibble_bus_reader.sv
// Randomized bench for nibble_bus_reader: three parameterizations against a word/latency model.
module tb_nibble_bus_reader;

    logic clk;
    logic rst_n;

    int turn_of[3] = '{1, 0, 3};
    int num_of[3]  = '{4, 2, 4};

    logic       start[3];
    logic       ready[3];
    logic [3:0] drv[3];
    logic       en[3];
    logic       valid[3];
    logic       bsy[3];
    logic [63:0] data[3];
    logic [3:0] pat[3][16];
    int         ecnt[3];

    int n_chk  = 0;
    int n_fail = 0;

    nibble_bus_reader_if #(.NIB_W(4), .NUM_NIB(4)) if0 ();
    nibble_bus_reader_if #(.NIB_W(4), .NUM_NIB(2)) if1 ();
    nibble_bus_reader_if #(.NIB_W(4), .NUM_NIB(4)) if2 ();

    nibble_bus_reader #(.NIB_W(4), .NUM_NIB(4), .TURN_CYC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    nibble_bus_reader #(.NIB_W(4), .NUM_NIB(2), .TURN_CYC(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    nibble_bus_reader #(.NIB_W(4), .NUM_NIB(4), .TURN_CYC(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.start = start[0];  assign if0.rd_ready = ready[0];  assign if0.bus_y = drv[0];
    assign if1.start = start[1];  assign if1.rd_ready = ready[1];  assign if1.bus_y = drv[1];
    assign if2.start = start[2];  assign if2.rd_ready = ready[2];  assign if2.bus_y = drv[2];
    assign en[0] = if0.bus_en;  assign valid[0] = if0.rd_valid;  assign bsy[0] = if0.busy;  assign data[0] = 64'(if0.rd_data);
    assign en[1] = if1.bus_en;  assign valid[1] = if1.rd_valid;  assign bsy[1] = if1.busy;  assign data[1] = 64'(if1.rd_data);
    assign en[2] = if2.bus_en;  assign valid[2] = if2.rd_valid;  assign bsy[2] = if2.busy;  assign data[2] = 64'(if2.rd_data);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus driver: after TURN_CYC enabled cycles it presents nibble k on the k-th following cycle.
    // A two-state sim cannot float the bus, so an undriven bus is modelled as random junk.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                drv[i] = (ecnt[i] >= turn_of[i]) ? pat[i][(ecnt[i] - turn_of[i]) % 16] : 4'($urandom);
                ecnt[i]++;
            end else begin
                ecnt[i] = 0;
                drv[i]  = 4'($urandom);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_word(input logic [3:0] p[16], input int n);
        logic [63:0] w = '0;
        for (int k = 0; k < n; k++) w = w + (64'(p[k]) << (4 * k));
        return w;
    endfunction

    // Start one read on instance i and stop once rd_valid is seen (or 100 cycles pass).
    task automatic run_read(input int i, input logic [3:0] p[16],
                            output int lat, output int en_cyc, output logic [63:0] word);
        pat[i] = p;
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        lat = 0;
        en_cyc = 0;
        while (!valid[i] && lat < 100) begin
            if (en[i]) en_cyc++;
            tick();
            lat++;
        end
        word = data[i];
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({en[i], bsy[i], valid[i], data[i]} !== 67'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: en=%b busy=%b valid=%b data=%h want all 0",
                         i, en[i], bsy[i], valid[i], data[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_read();
        logic [3:0] p[16];
        int lat, enc;
        logic [63:0] w;
        foreach (p[k]) p[k] = 4'h0;
        p[0] = 4'h0; p[1] = 4'hF; p[2] = 4'hA; p[3] = 4'h5;
        ready[0] = 1'b0;
        run_read(0, p, lat, enc, w);
        n_chk++;
        if (lat !== 6) begin n_fail++; $display("FAIL default_latency: got %0d want 6", lat); end
        n_chk++;
        if (enc !== 5) begin n_fail++; $display("FAIL default_bus_en_cycles: got %0d want 5", enc); end
        n_chk++;
        if (w !== 64'h5AF0) begin n_fail++; $display("FAIL default_data: got %h want 5af0", w); end
    endtask

    // Continues from HOLD left by test_default_read.
    task automatic test_stall();
        for (int c = 0; c < 20; c++) begin
            start[0] = (c == 5);
            tick();
            start[0] = 1'b0;
            n_chk++;
            if ({valid[0], en[0], data[0]} !== {1'b1, 1'b0, 64'h5AF0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b en=%b data=%h want 1 0 5af0", c, valid[0], en[0], data[0]);
            end
        end
        ready[0] = 1'b1;
        tick();
        ready[0] = 1'b0;
        n_chk++;
        if ({valid[0], bsy[0], data[0]} !== {1'b0, 1'b0, 64'h5AF0}) begin
            n_fail++;
            $display("FAIL stall_accept: valid=%b busy=%b data=%h want 0 0 5af0", valid[0], bsy[0], data[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] p[16];
        int lat, enc;
        logic [63:0] w;
        foreach (p[k]) p[k] = 4'($urandom);
        run_read(0, p, lat, enc, w);
        n_chk++;
        if (w !== exp_word(p, 4)) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", w, exp_word(p, 4)); end
        // start coincides with the accepting edge and must be dropped
        ready[0] = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        n_chk++;
        if ({bsy[0], valid[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_start_ignored: busy=%b valid=%b want 0 0", bsy[0], valid[0]);
        end
        foreach (p[k]) p[k] = 4'($urandom);
        run_read(0, p, lat, enc, w);
        n_chk++;
        if (lat !== 6 || w !== exp_word(p, 4)) begin
            n_fail++;
            $display("FAIL b2b_second: lat=%0d data=%h want 6 %h", lat, w, exp_word(p, 4));
        end
        tick();
        ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_sample();
        logic [3:0] p[16];
        int lat, enc;
        logic [63:0] w;
        foreach (p[k]) p[k] = 4'h0;
        p[0] = 4'h9; p[1] = 4'h8; p[2] = 4'h7; p[3] = 4'h6;
        pat[0] = p;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (en[0] !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_en: got %b want 1", en[0]); end
        #3 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({en[0], bsy[0], valid[0], data[0]} !== 67'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: en=%b busy=%b valid=%b data=%h want all 0", en[0], bsy[0], valid[0], data[0]);
        end
        #1 rst_n = 1'b1;
        tick();
        p[0] = 4'h1; p[1] = 4'h2; p[2] = 4'h3; p[3] = 4'h4;
        run_read(0, p, lat, enc, w);
        n_chk++;
        if (lat !== 6 || w !== 64'h4321) begin
            n_fail++;
            $display("FAIL midreset_fresh_read: lat=%0d data=%h want 6 4321", lat, w);
        end
        ready[0] = 1'b1;
        tick();
        ready[0] = 1'b0;
    endtask

    task automatic test_sweep_turn0();
        logic [3:0] p[16];
        int lat, enc;
        logic [63:0] w;
        foreach (p[k]) p[k] = 4'h0;
        p[0] = 4'h3; p[1] = 4'hC;
        run_read(1, p, lat, enc, w);
        n_chk++;
        if (lat !== 3 || enc !== 2 || w !== 64'hC3) begin
            n_fail++;
            $display("FAIL sweep_turn0: lat=%0d en_cyc=%0d data=%h want 3 2 c3", lat, enc, w);
        end
        ready[1] = 1'b1;
        tick();
        ready[1] = 1'b0;
    endtask

    task automatic test_sweep_turn3();
        logic [3:0] p[16];
        int lat, enc;
        logic [63:0] w;
        foreach (p[k]) p[k] = 4'($urandom);
        run_read(2, p, lat, enc, w);
        n_chk++;
        if (lat !== 8 || enc !== 7 || w !== exp_word(p, 4)) begin
            n_fail++;
            $display("FAIL sweep_turn3: lat=%0d en_cyc=%0d data=%h want 8 7 %h", lat, enc, w, exp_word(p, 4));
        end
        ready[2] = 1'b1;
        tick();
        ready[2] = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] p[16];
        int lat, enc, i, stall;
        logic [63:0] w;
        for (int it = 0; it < 12; it++) begin
            i = int'($urandom_range(0, 2));
            stall = int'($urandom_range(0, 3));
            foreach (p[k]) p[k] = 4'($urandom);
            run_read(i, p, lat, enc, w);
            n_chk++;
            if (lat !== turn_of[i] + num_of[i] + 1 || enc !== turn_of[i] + num_of[i]
                || w !== exp_word(p, num_of[i])) begin
                n_fail++;
                $display("FAIL random_read[%0d] inst %0d: lat=%0d en_cyc=%0d data=%h want %0d %0d %h",
                         it, i, lat, enc, w, turn_of[i] + num_of[i] + 1, turn_of[i] + num_of[i],
                         exp_word(p, num_of[i]));
            end
            for (int s = 0; s < stall; s++) begin
                tick();
                n_chk++;
                if ({valid[i], data[i]} !== {1'b1, w}) begin
                    n_fail++;
                    $display("FAIL random_stall[%0d]: valid=%b data=%h want 1 %h", it, valid[i], data[i], w);
                end
            end
            ready[i] = 1'b1;
            tick();
            ready[i] = 1'b0;
            n_chk++;
            if ({valid[i], bsy[i]} !== 2'b00) begin
                n_fail++;
                $display("FAIL random_accept[%0d]: valid=%b busy=%b want 0 0", it, valid[i], bsy[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b0;
        end
        test_reset();
        test_default_read();
        test_stall();
        test_back_to_back();
        test_reset_mid_sample();
        test_sweep_turn0();
        test_sweep_turn3();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
